// File: rtl/aes_pkg.sv
// AES inverse-cipher shared types, constants and GF(2^8) byte helpers.
// Used by aes_inv_round and aes_invcipher_iter.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NK_128 = 4;
  localparam int NK_192 = 6;
  localparam int NK_256 = 8;

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse; 0 maps to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  // Inverse affine transform followed by field inversion
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]}
      ^ {x[4:0], x[7:5]}
      ^ {x[1:0], x[7:2]}
      ^ 8'h05;
    return ginv(y);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    b0 = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
       ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
    b1 = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
       ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
    b2 = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
       ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
    b3 = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
       ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES decryption round:
// InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns unless last.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] stm,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] nxt
);

  logic [127:0] sr;
  logic [127:0] sb;
  logic [127:0] ak;
  logic [127:0] mc;

  // Row r rotates right by r columns, then bytewise inverse S-box
  always_comb begin
    sr = '0;
    sb = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] =
          stm[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    for (int n = 0; n < 16; n++) begin
      sb[127-8*n -: 8] = inv_sbox(sr[127-8*n -: 8]);
    end
  end

  assign ak = sb ^ rk;

  // Column-wise InvMixColumns on the key-added state
  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = inv_mix_col(ak[127-32*c -: 32]);
    end
  end

  assign nxt = last ? ak : mc;

endmodule

// File: rtl/aes_invcipher_iter.sv
// Iterative AES-128/192/256 inverse cipher, one round per clock.
// Optional abort input enabled by AES_INVCIPHER_ABORT_EN.
module aes_invcipher_iter
  import aes_pkg::*;
#(
  parameter int NK    = 4,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef AES_INVCIPHER_ABORT_EN
  input  logic             abort,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic [IDX_W-1:0] rk_idx,
  input  logic [127:0]     rk_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data
);

  localparam int NR = nr_of(NK);
  localparam logic [IDX_W-1:0] NR_IDX = IDX_W'(NR);
  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  if (!(NK == NK_128 || NK == NK_192 || NK == NK_256)) begin : g_bad_nk
    $error("aes_invcipher_iter: NK must be 4, 6 or 8");
  end

  if ((1 << IDX_W) <= NR) begin : g_bad_idx
    $error("aes_invcipher_iter: IDX_W too narrow for NR");
  end

  state_t           state;
  logic [IDX_W-1:0] rnd;
  logic [127:0]     stm;
  logic [127:0]     rnd_out;
  logic             last;
  logic             kill;
  logic             accept;

`ifdef AES_INVCIPHER_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  // Ready and key index decode from the current state
  always_comb begin
    in_ready = 1'b0;
    rk_idx   = NR_IDX;
    unique case (state)
      IDLE:    in_ready = !kill;
      ROUND:   rk_idx = rnd;
      DONE:    in_ready = out_ready && !kill;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign last     = (rnd == '0);
  assign out_data = stm;

  aes_inv_round u_round (
    .stm  (stm),
    .rk   (rk_data),
    .last (last),
    .nxt  (rnd_out)
  );

  // Control FSM and datapath state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      rnd       <= NR_IDX;
      stm       <= '0;
      out_valid <= 1'b0;
    end else if (kill && state != IDLE) begin
      state     <= IDLE;
      rnd       <= NR_IDX;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            stm   <= in_data ^ rk_data;
            rnd   <= NR_IDX - ONE;
            state <= ROUND;
          end
        end
        ROUND: begin
          stm <= rnd_out;
          if (last) begin
            rnd       <= NR_IDX;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            rnd <= rnd - ONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (accept) begin
              stm   <= in_data ^ rk_data;
              rnd   <= NR_IDX - ONE;
              state <= ROUND;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          rnd       <= NR_IDX;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_invcipher_iter.sv
// Directed bench for aes_invcipher_iter at NK=4/6/8 with FIPS-197 vectors.
// Key schedules are expanded in the bench from the 000102.. keys.
module tb_aes_invcipher_iter;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_data   [3];
  logic [3:0]   rk_idx    [3];
  logic [127:0] rk_data   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_data  [3];
  logic [127:0] rks       [3][16];
  logic [127:0] ct        [3];
`ifdef AES_INVCIPHER_ABORT_EN
  logic         abort;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_invcipher_iter #(.NK(4 + 2*g), .IDX_W(4)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
`ifdef AES_INVCIPHER_ABORT_EN
      .abort     (abort),
`endif
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .rk_idx    (rk_idx[g]),
      .rk_data   (rk_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g])
    );
    assign rk_data[g] = rks[g][rk_idx[g]];
  end

  task automatic chk_v(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag,
                       input logic obs,
                       input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag,
                       input int obs,
                       input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tb_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] tb_mul(input logic [7:0] a,
                                        input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = tb_xt(x);
    end
    return p;
  endfunction

  // Forward S-box: brute-force inverse, then forward affine
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (tb_mul(x, 8'(y)) == 8'h01) v = 8'(y);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox(t[31:24]), sbox(t[23:16]),
            sbox(t[15:8]), sbox(t[7:0])};
  endfunction

  task automatic expand(input int k);
    int nk;
    int nr;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    nk = 4 + 2*k;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++)
      w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = tb_xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nr)
        rks[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else
        rks[k][r] = '0;
    end
  endtask

  // Accept ct[k] from IDLE; return after out_valid or timeout.
  // lat counts clock edges including the acceptance edge.
  task automatic run_block(input int k, input bit trace,
                           output int lat);
    int nr;
    nr = 10 + 2*k;
    @(negedge clk);
    in_valid[k] = 1'b1;
    in_data[k]  = ct[k];
    #1;
    chk_b("in_ready_idle", in_ready[k], 1'b1);
    if (trace) chk_i("rk_idx_seq", int'(rk_idx[k]), nr);
    @(posedge clk);
    #1;
    lat = 1;
    in_valid[k] = 1'b0;
    in_data[k]  = '1;
    while (!out_valid[k] && lat < 40) begin
      if (trace) begin
        chk_i("rk_idx_seq", int'(rk_idx[k]), nr - lat);
        chk_b("in_ready_round", in_ready[k], 1'b0);
      end
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int nr;
    int t [3];
    bit seen;
    ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    ct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    ct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
    reset_n = 1'b0;
`ifdef AES_INVCIPHER_ABORT_EN
    abort = 1'b0;
`endif
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = '0;
      out_ready[k] = 1'b1;
      expand(k);
    end
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < 3; k++) begin
      chk_b("rst_in_ready", in_ready[k], 1'b1);
      chk_b("rst_out_valid", out_valid[k], 1'b0);
      chk_v("rst_out_data", out_data[k], '0);
      chk_i("rst_rk_idx", int'(rk_idx[k]), 10 + 2*k);
    end
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 3; k++) begin
      nr = 10 + 2*k;
      run_block(k, k == 0, lat);
      chk_i("latency", lat, nr + 1);
      chk_v("plaintext", out_data[k], PT);
      chk_b("done_in_ready", in_ready[k], 1'b1);
      chk_i("done_rk_idx", int'(rk_idx[k]), nr);
      @(posedge clk);
      #1;
      chk_b("after_xfer_valid", out_valid[k], 1'b0);
    end

    @(negedge clk);
    out_ready[0] = 1'b0;
    run_block(0, 1'b0, lat);
    chk_i("bp_latency", lat, 11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid[0] = 1'b1;
      in_data[0]  = ct[1];
      #1;
      chk_b("bp_valid", out_valid[0], 1'b1);
      chk_v("bp_data", out_data[0], PT);
      chk_b("bp_in_ready", in_ready[0], 1'b0);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    #1;
    chk_b("bp_release_ready", in_ready[0], 1'b1);
    chk_v("bp_release_data", out_data[0], PT);
    @(posedge clk);
    #1;
    chk_b("bp_single_xfer", out_valid[0], 1'b0);
    @(posedge clk);
    #1;
    chk_b("bp_stay_idle", out_valid[0], 1'b0);
    chk_i("bp_idle_rk_idx", int'(rk_idx[0]), 10);

    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = ct[0];
    @(posedge clk);
    #1;
    for (int b = 0; b < 3; b++) begin
      lat = 0;
      while (!out_valid[0] && lat < 40) begin
        @(posedge clk);
        #1;
        lat++;
      end
      t[b] = cyc;
      chk_b("b2b_valid", out_valid[0], 1'b1);
      chk_v("b2b_data", out_data[0], PT);
      chk_b("b2b_ready_pulse", in_ready[0], 1'b1);
      if (b == 2) in_valid[0] = 1'b0;
      @(posedge clk);
      #1;
      chk_b("b2b_next_valid", out_valid[0], 1'b0);
      chk_b("b2b_next_ready", in_ready[0], b == 2);
    end
    chk_i("b2b_spacing1", t[1] - t[0], 11);
    chk_i("b2b_spacing2", t[2] - t[1], 11);

    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = ct[0];
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk_b("mid_rst_in_ready", in_ready[0], 1'b1);
    chk_b("mid_rst_valid", out_valid[0], 1'b0);
    chk_v("mid_rst_data", out_data[0], '0);
    chk_i("mid_rst_rk_idx", int'(rk_idx[0]), 10);
    @(negedge clk);
    reset_n = 1'b1;
    run_block(0, 1'b0, lat);
    chk_i("post_rst_latency", lat, 11);
    chk_v("post_rst_data", out_data[0], PT);
    @(posedge clk);
    #1;

`ifdef AES_INVCIPHER_ABORT_EN
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = ct[0];
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk_b("abort_valid", out_valid[0], 1'b0);
    chk_i("abort_rk_idx", int'(rk_idx[0]), 10);
    chk_b("abort_blocks_ready", in_ready[0], 1'b0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk_b("abort_idle_ready", in_ready[0], 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (out_valid[0]) seen = 1'b1;
    end
    chk_b("abort_no_output", seen, 1'b0);

    @(negedge clk);
    out_ready[0] = 1'b0;
    run_block(0, 1'b0, lat);
    chk_v("abort_done_data", out_data[0], PT);
    @(negedge clk);
    abort        = 1'b1;
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_data[0]   = ct[0];
    #1;
    chk_b("abort_done_ready", in_ready[0], 1'b0);
    @(posedge clk);
    #1;
    chk_b("abort_done_valid", out_valid[0], 1'b0);
    @(negedge clk);
    abort       = 1'b0;
    in_valid[0] = 1'b0;
    #1;
    chk_b("abort_done_idle", in_ready[0], 1'b1);
    chk_i("abort_done_rk_idx", int'(rk_idx[0]), 10);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_invcipher_iter.md
Name: aes_invcipher_iter

Overview:
Parametrised iterative AES inverse cipher: one decryption round per cycle, supporting AES-128/192/256 via NK. Adds valid/ready handshakes on input and output, and drives a round-key index so an external key-schedule store (RAM or expander) supplies keys in reverse order. Sits between the block-mode/streaming front end and the key schedule, replacing fixed 128-bit, free-running decryption.

Parameters:
NK, 4, key length in 32-bit words (4/6/8); NR = NK+6 rounds (10/12/14); other values rejected by elaboration assertion
IDX_W, 4, width of rk_idx; must satisfy 2^IDX_W > NR

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
in_valid  in  1  ciphertext block valid
in_ready  out  1  block can accept ciphertext this cycle
in_data  in  128  ciphertext block, FIPS-197 byte order (byte 0 in [127:120])
rk_idx  out  IDX_W  round-key index requested this cycle (0..NR), combinational from state/counter
rk_data  in  128  round key for rk_idx, valid in the same cycle (combinational read)
out_valid  out  1  plaintext valid
out_ready  in  1  downstream accepts plaintext
out_data  out  128  plaintext block, registered

Behaviour:
- States: IDLE, ROUND, DONE. Round counter rnd (IDX_W bits).
- Reset (reset_n=0 at clk edge): state=IDLE, rnd=NR, stm=0; outputs in_ready=1, out_valid=0, out_data=0, rk_idx=NR. Reset mid-operation discards the block; no output produced.
- IDLE: in_ready=1, rk_idx=NR. On in_valid: stm <= in_data ^ rk_data; rnd <= NR-1; go ROUND.
- ROUND: in_ready=0, rk_idx=rnd. If rnd>=1: stm <= InvMixColumns(InvSubBytes(InvShiftRows(stm)) ^ rk_data); rnd <= rnd-1. If rnd==0: stm <= InvSubBytes(InvShiftRows(stm)) ^ rk_data; go DONE.
- DONE: out_valid=1, out_data=stm stable until handshake. in_ready=out_ready; rk_idx=NR.
  - out_ready=0: hold everything (in_valid ignored).
  - out_ready=1, in_valid=0: go IDLE.
  - out_ready=1, in_valid=1: output handshake and new acceptance in the same cycle; behaves as the IDLE acceptance; go ROUND. Zero bubble.
- Latency: acceptance edge at cycle 0, out_valid high from cycle NR+1 (11/13/15 edges). Throughput: one block per NR+1 cycles.
- in_data sampled only on acceptance; later changes ignored. rk_data sampled every cycle in IDLE, ROUND and accepting DONE only.
- Unused state encodings return to IDLE with out_valid=0.

Optional Feature:
AES_INVCIPHER_ABORT_EN: adds input port abort (1 bit). abort=1 in ROUND or DONE sends the block to IDLE next cycle with out_valid=0, rnd=NR; in IDLE it blocks acceptance (in_ready=0 that cycle). Abort has priority over the DONE handshake. Without the macro: no port; blocks always complete.

Decomposition:
- aes_pkg: state enum (IDLE/ROUND/DONE), function nr_of(nk), constants NK_128=4, NK_192=6, NK_256=8.
- Sub-module aes_inv_round (combinational): inputs stm, rk, last; output next state. Built from the existing invshiftrows, invsubbytes and invmixcolumns; the last input bypasses InvMixColumns.

Test Plan:
- NK=4, key 000102..0f schedule model, in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff; out_valid exactly 11 cycles after acceptance; rk_idx sequence 10,9,..,0.
- NK=6, key 000102..17, in_data dda97ca4864cdfe06eaf70a0ec0d7191 -> same plaintext; latency 13 cycles. NK=8, key 000102..1f, in_data 8ea2b7ca516745bfeafc49904b496089 -> same plaintext; latency 15 cycles.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_data/out_valid held, in_ready=0, stm unchanged; then out_ready=1 -> single transfer.
- Back-to-back: in_valid held high with 3 blocks, out_ready=1 -> in_ready pulses in DONE; 3 correct outputs at 11-cycle spacing (NK=4).
- Reset: reset_n=0 at round 5 -> next cycle in_ready=1, out_valid=0, out_data=0, rk_idx=NR; next block decrypts correctly.
- With AES_INVCIPHER_ABORT_EN: abort at round 3 -> IDLE next cycle, no out_valid; abort coincident with the DONE handshake -> no transfer.
